// File: rtl/main_clock.sv
// 24-hour alarm clock: 1 Hz divider, HH:MM:SS counters with button adjust, alarm, 7-seg display.
// Optional macro HOURLY_CHIME_EN also lights LEDAlarm for the last 5 s of every hour.
module main_clock #(
  parameter int CLK_DIV     = 50_000_000,
  parameter int ALARM_RST_H = 6,
  parameter int ALARM_RST_M = 0
) (
  input  logic       CP50,
  input  logic       nCR,
  input  logic       Ctrl24To12,
  input  logic       EN,
  input  logic       SwitchMHToS,
  input  logic       DisplayA,
  input  logic       AdjH,
  input  logic       AdjM,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       LEDAlarm,
  output logic       LED0
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [5:0]       t_sec, t_min, al_m;
  logic [4:0]       t_hour, al_h;

  logic adj_th, adj_tm, adj_ah, adj_am;
  logic sec_carry, min_carry;
  logic alarm_match, chime;
  logic [5:0] left_val, right_val;
  logic [4:0] src_hour;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] fmt_hour(input logic [4:0] h, input logic mode12);
    if (!mode12)         return {1'b0, h};
    else if (h == 5'd0)  return 6'd12;
    else if (h > 5'd12)  return {1'b0, h - 5'd12};
    else                 return {1'b0, h};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // An adjusted field ignores its natural carry-in and never produces a carry-out.
  always_comb begin
    adj_th    = AdjH & ~DisplayA;
    adj_tm    = AdjM & ~DisplayA;
    adj_ah    = AdjH & DisplayA;
    adj_am    = AdjM & DisplayA;
    sec_carry = EN & (t_sec == 6'd59);
    min_carry = sec_carry & (t_min == 6'd59) & ~adj_tm;
  end

  always_comb begin
    alarm_match = EN & (t_hour == al_h) & (t_min == al_m);
`ifdef HOURLY_CHIME_EN
    chime = EN & (t_min == 6'd59) & (t_sec >= 6'd55);
`else
    chime = 1'b0;
`endif
  end

  always_ff @(posedge CP50 or negedge nCR) begin
    if (!nCR) begin
      div_cnt  <= '0;
      t_sec    <= '0;
      t_min    <= '0;
      t_hour   <= '0;
      al_h     <= 5'(ALARM_RST_H);
      al_m     <= 6'(ALARM_RST_M);
      LEDAlarm <= 1'b0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;
      LEDAlarm <= alarm_match | chime;
      if (tick) begin
        if (EN)                 t_sec  <= inc60(t_sec);
        if (adj_tm || sec_carry) t_min  <= inc60(t_min);
        if (adj_th || min_carry) t_hour <= inc24(t_hour);
        if (adj_ah)             al_h   <= inc24(al_h);
        if (adj_am)             al_m   <= inc60(al_m);
      end
    end
  end

  always_comb begin
    if (DisplayA) begin
      left_val  = fmt_hour(al_h, Ctrl24To12);
      right_val = al_m;
    end else if (SwitchMHToS) begin
      left_val  = t_min;
      right_val = t_sec;
    end else begin
      left_val  = fmt_hour(t_hour, Ctrl24To12);
      right_val = t_min;
    end
    src_hour = DisplayA ? al_h : t_hour;
    LED0     = Ctrl24To12 & (src_hour >= 5'd12);
  end

  assign HEX3 = seg7(4'(left_val / 6'd10));
  assign HEX2 = seg7(4'(left_val % 6'd10));
  assign HEX1 = seg7(4'(right_val / 6'd10));
  assign HEX0 = seg7(4'(right_val % 6'd10));

endmodule

// File: tb/tb_main_clock.sv
// Self-checking bench for main_clock: directed scenarios plus randomized inputs against a
// behavioural time/alarm model, expected display words queued and popped per check.
module tb_main_clock;

  localparam int CLK_DIV = 4;
`ifdef HOURLY_CHIME_EN
  localparam bit CHIME = 1'b1;
`else
  localparam bit CHIME = 1'b0;
`endif

  logic CP50 = 1'b0;
  logic nCR = 1'b1;
  logic Ctrl24To12 = 1'b0, EN = 1'b0, SwitchMHToS = 1'b0, DisplayA = 1'b0;
  logic AdjH = 1'b0, AdjM = 1'b0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic LEDAlarm, LED0;

  always #5 CP50 = ~CP50;

  main_clock #(.CLK_DIV(CLK_DIV), .ALARM_RST_H(6), .ALARM_RST_M(0)) dut (
    .CP50(CP50), .nCR(nCR), .Ctrl24To12(Ctrl24To12), .EN(EN),
    .SwitchMHToS(SwitchMHToS), .DisplayA(DisplayA), .AdjH(AdjH), .AdjM(AdjM),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .LEDAlarm(LEDAlarm), .LED0(LED0)
  );

  logic [29:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int ph = 0;
  int m_h, m_m, m_s, a_h, a_m;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Word layout: {HEX3, HEX2, HEX1, HEX0, LEDAlarm, LED0}
  function automatic logic [29:0] dut_word();
    return {HEX3, HEX2, HEX1, HEX0, LEDAlarm, LED0};
  endfunction

  function automatic logic [29:0] w(int l, int r, bit la, bit l0);
    return {seg_tab[l / 10], seg_tab[l % 10], seg_tab[r / 10], seg_tab[r % 10], la, l0};
  endfunction

  function automatic int fmt_h(int h);
    if (!Ctrl24To12) return h;
    if (h == 0)      return 12;
    if (h > 12)      return h - 12;
    return h;
  endfunction

  function automatic logic [29:0] model_word();
    int l, r, sh;
    bit la, l0;
    if (DisplayA)         begin l = fmt_h(a_h); r = a_m; end
    else if (SwitchMHToS) begin l = m_m;        r = m_s; end
    else                  begin l = fmt_h(m_h); r = m_m; end
    sh = DisplayA ? a_h : m_h;
    l0 = Ctrl24To12 && (sh >= 12);
    la = EN && (m_h == a_h) && (m_m == a_m);
    if (CHIME && EN && m_m == 59 && m_s >= 55) la = 1'b1;
    return w(l, r, la, l0);
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; a_h = 6; a_m = 0;
  endtask

  task automatic model_tick();
    bit sc, mc;
    sc = EN && (m_s == 59);
    mc = sc && (m_m == 59) && !(AdjM && !DisplayA);
    if (EN) m_s = (m_s + 1) % 60;
    if (!DisplayA) begin
      if (AdjM || sc) m_m = (m_m + 1) % 60;
      if (AdjH || mc) m_h = (m_h + 1) % 24;
    end else begin
      if (sc) m_m = (m_m + 1) % 60;
      if (mc) m_h = (m_h + 1) % 24;
      if (AdjH) a_h = (a_h + 1) % 24;
      if (AdjM) a_m = (a_m + 1) % 60;
    end
  endtask

  task automatic step_edge();
    @(posedge CP50);
    if (ph == CLK_DIV - 1) begin
      ph = 0;
      model_tick();
    end else begin
      ph++;
    end
  endtask

  task automatic run_ticks(int n);
    repeat (n) begin
      step_edge();
      while (ph != 0) step_edge();
    end
    @(negedge CP50);
  endtask

  // One non-tick edge so the registered LEDAlarm reflects the current time and inputs.
  task automatic settle();
    step_edge();
    while (ph == 0) step_edge();
    @(negedge CP50);
  endtask

  task automatic do_reset();
    nCR = 1'b0;
    {Ctrl24To12, EN, SwitchMHToS, DisplayA, AdjH, AdjM} = '0;
    model_reset();
    @(negedge CP50);
    nCR = 1'b1;
    ph = 0;
  endtask

  task automatic test_reset();
    logic [29:0] e;
    #2 nCR = 1'b0;
    model_reset();
    @(negedge CP50);
    exp_q.push_back(w(0, 0, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", dut_word(), e); end
    nCR = 1'b1;
    ph = 0;
    exp_q.push_back(w(0, 0, 0, 0));
    repeat (100) step_edge();
    @(negedge CP50);
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_word(), e); end
    EN = 1'b1; SwitchMHToS = 1'b1;
    exp_q.push_back(w(0, 7, 0, 0));
    run_ticks(7);
    step_edge();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL pre_reset: got %h expected %h", dut_word(), e); end
    @(negedge CP50);
    nCR = 1'b0;
    exp_q.push_back(w(0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL reset_async: got %h expected %h", dut_word(), e); end
  endtask

  task automatic test_divider();
    logic [29:0] e;
    do_reset();
    EN = 1'b1; SwitchMHToS = 1'b1;
    exp_q.push_back(w(0, 0, 0, 0));
    repeat (CLK_DIV - 1) step_edge();
    @(negedge CP50);
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL div_pre_tick: got %h expected %h", dut_word(), e); end
    exp_q.push_back(w(0, 1, 0, 0));
    step_edge();
    @(negedge CP50);
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL div_first_tick: got %h expected %h", dut_word(), e); end
  endtask

  task automatic test_sec_rollover();
    logic [29:0] e;
    do_reset();
    EN = 1'b1; SwitchMHToS = 1'b1;
    exp_q.push_back(w(1, 0, 0, 0));
    run_ticks(60);
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL sec_rollover: got %h expected %h", dut_word(), e); end
  endtask

  task automatic test_hour_adjust();
    logic [29:0] e;
    do_reset();
    AdjH = 1'b1; run_ticks(13); AdjH = 1'b0;
    exp_q.push_back(w(13, 0, 0, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL hour_13_24h: got %h expected %h", dut_word(), e); end
    Ctrl24To12 = 1'b1;
    exp_q.push_back(w(1, 0, 0, 1));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL hour_13_12h: got %h expected %h", dut_word(), e); end
    AdjH = 1'b1; run_ticks(11); AdjH = 1'b0;
    exp_q.push_back(w(12, 0, 0, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL hour_wrap_12h: got %h expected %h", dut_word(), e); end
    Ctrl24To12 = 1'b0;
    exp_q.push_back(w(0, 0, 0, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL hour_wrap_24h: got %h expected %h", dut_word(), e); end
  endtask

  task automatic test_alarm();
    logic [29:0] e;
    do_reset();
    DisplayA = 1'b1; AdjM = 1'b1; run_ticks(1); AdjM = 1'b0;
    exp_q.push_back(w(6, 1, 0, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL alarm_set: got %h expected %h", dut_word(), e); end
    DisplayA = 1'b0;
    AdjH = 1'b1; run_ticks(6); AdjH = 1'b0;
    AdjM = 1'b1; run_ticks(1); AdjM = 1'b0;
    EN = 1'b1;
    exp_q.push_back(w(6, 1, 1, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL alarm_match: got %h expected %h", dut_word(), e); end
    exp_q.push_back(w(6, 1, 1, 0));
    run_ticks(59);
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL alarm_hold: got %h expected %h", dut_word(), e); end
    exp_q.push_back(w(6, 2, 0, 0));
    run_ticks(1);
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL alarm_clear: got %h expected %h", dut_word(), e); end
    EN = 1'b0;
    AdjM = 1'b1; run_ticks(59); AdjM = 1'b0;
    exp_q.push_back(w(6, 1, 0, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL alarm_en_off: got %h expected %h", dut_word(), e); end
  endtask

  task automatic test_carry_suppress();
    logic [29:0] e;
    do_reset();
    AdjM = 1'b1; run_ticks(59); AdjM = 1'b0;
    EN = 1'b1; run_ticks(59);
    SwitchMHToS = 1'b1;
    exp_q.push_back(w(59, 59, 0, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL carry_pre: got %h expected %h", dut_word(), e); end
    AdjM = 1'b1; run_ticks(1); AdjM = 1'b0; EN = 1'b0;
    exp_q.push_back(w(0, 0, 0, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL carry_mmss: got %h expected %h", dut_word(), e); end
    SwitchMHToS = 1'b0;
    exp_q.push_back(w(0, 0, 0, 0));
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL carry_hhmm: got %h expected %h", dut_word(), e); end
  endtask

  task automatic test_chime();
    logic [29:0] e;
    do_reset();
    AdjM = 1'b1; run_ticks(59); AdjM = 1'b0;
    EN = 1'b1; SwitchMHToS = 1'b1;
    exp_q.push_back(w(59, 54, 0, 0));
    run_ticks(54);
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL chime_54: got %h expected %h", dut_word(), e); end
    exp_q.push_back(w(59, 55, CHIME, 0));
    run_ticks(1);
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL chime_55: got %h expected %h", dut_word(), e); end
    exp_q.push_back(w(59, 59, CHIME, 0));
    run_ticks(4);
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL chime_59: got %h expected %h", dut_word(), e); end
    exp_q.push_back(w(0, 0, 0, 0));
    run_ticks(1);
    settle();
    e = exp_q.pop_front(); n_checks++;
    if (dut_word() !== e) begin n_fail++; $display("FAIL chime_hour: got %h expected %h", dut_word(), e); end
  endtask

  task automatic test_random();
    logic [29:0] e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      EN          = 1'($urandom_range(0, 1));
      SwitchMHToS = 1'($urandom_range(0, 1));
      DisplayA    = 1'($urandom_range(0, 1));
      Ctrl24To12  = 1'($urandom_range(0, 1));
      AdjH        = 1'($urandom_range(0, 1));
      AdjM        = 1'($urandom_range(0, 1));
      run_ticks($urandom_range(1, 30));
      AdjH = 1'b0; AdjM = 1'b0;
      exp_q.push_back(model_word());
      settle();
      e = exp_q.pop_front(); n_checks++;
      if (dut_word() !== e) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h (t=%0d:%0d:%0d a=%0d:%0d)",
                 i, dut_word(), e, m_h, m_m, m_s, a_h, a_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_sec_rollover();
    test_hour_adjust();
    test_alarm();
    test_carry_suppress();
    test_chime();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
